// File: rtl/mux_scan_ctrl_if.sv
// -----------------------------------------------------------------------------
// mux_scan_ctrl_if
// Groups the scan handshake and the 8-to-1 mux connections of mux_scan_ctrl.
//
// Signals:
//   start  : scan request (sampled only while the controller is idle)
//   abort  : terminates an active scan
//   y      : Y output of the external 8-to-1 mux being scanned
//   sel    : mux select, sel[2]=S2, sel[1]=S1, sel[0]=S0
//   g_n    : active-low mux enable (G_n)
//   busy   : controller not idle
//   done   : one-cycle pulse after a complete scan
//   data   : captured channels, data[i] = D(i)
//   parity : XOR of the captured channels (only with MUX_SCAN_PARITY_EN)
//
// Modports:
//   master : the side that requests scans and owns the mux (drives start/abort/y)
//   slave  : the controller itself
//
// Build option: define MUX_SCAN_PARITY_EN to add the parity signal.
// -----------------------------------------------------------------------------
interface mux_scan_ctrl_if;
  logic       start;
  logic       abort;
  logic       y;
  logic [2:0] sel;
  logic       g_n;
  logic       busy;
  logic       done;
  logic [7:0] data;
`ifdef MUX_SCAN_PARITY_EN
  logic       parity;

  modport master (
    output start, abort, y,
    input  sel, g_n, busy, done, data, parity
  );

  modport slave (
    input  start, abort, y,
    output sel, g_n, busy, done, data, parity
  );
`else
  modport master (
    output start, abort, y,
    input  sel, g_n, busy, done, data
  );

  modport slave (
    input  start, abort, y,
    output sel, g_n, busy, done, data
  );
`endif
endinterface

// File: rtl/mux_scan_ctrl.sv
// -----------------------------------------------------------------------------
// mux_scan_ctrl
// Walks the select lines of an external 8-to-1 mux through channels 0..7,
// holds each select value for SETTLE cycles so the mux output can settle,
// then captures Y into data[sel]. A full scan ends with a one-cycle done
// pulse; an abort ends it early, keeping whatever channels were already
// captured.
//
// Parameters:
//   SETTLE : cycles each select value is held before Y is sampled (1..4)
//
// Ports:
//   clk  : clock, all state changes on the rising edge
//   rst  : asynchronous, active-high reset
//   bus  : mux_scan_ctrl_if.slave (start, abort, y, sel, g_n, busy, done,
//          data and, when enabled, parity)
//
// Build option: MUX_SCAN_PARITY_EN adds the registered parity output
// (XOR of the eight captured bits, updated when a full scan completes).
//
// All outputs come straight from registers.
// -----------------------------------------------------------------------------
module mux_scan_ctrl #(
  parameter int SETTLE = 1
) (
  input  logic            clk,
  input  logic            rst,
  mux_scan_ctrl_if.slave  bus
);

  // State encoding
  localparam logic [1:0] S_IDLE = 2'b00;
  localparam logic [1:0] S_SCAN = 2'b01;
  localparam logic [1:0] S_DONE = 2'b10;

  // Last value of the hold counter before Y is sampled (SETTLE is 1..4).
  localparam logic [1:0] CNT_LAST = 2'(SETTLE - 1);

  logic [1:0] state_q, state_d;
  logic [1:0] cnt_q,   cnt_d;
  logic [2:0] sel_q,   sel_d;
  logic       g_n_q,   g_n_d;
  logic       busy_q,  busy_d;
  logic       done_q,  done_d;
  logic [7:0] data_q,  data_d;

`ifdef MUX_SCAN_PARITY_EN
  logic       parity_q, parity_d;

  // Even parity across the eight captured channels.
  function automatic logic calc_parity(input logic [7:0] bits);
    calc_parity = ^bits;
  endfunction
`endif

  // Next-state and output-register logic for the scan sequencer
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sel_d   = sel_q;
    g_n_d   = g_n_q;
    data_d  = data_q;
    done_d  = 1'b0;
`ifdef MUX_SCAN_PARITY_EN
    parity_d = parity_q;
`endif

    case (state_q)
      S_IDLE: begin
        // abort wins over a simultaneous start
        if (bus.start && !bus.abort) begin
          state_d = S_SCAN;
          sel_d   = 3'd0;
          g_n_d   = 1'b0;
          cnt_d   = 2'd0;
        end else begin
          state_d = S_IDLE;
        end
      end

      S_SCAN: begin
        if (bus.abort) begin
          // Leave already-captured channels untouched; no sample on this edge.
          state_d = S_IDLE;
          g_n_d   = 1'b1;
          sel_d   = 3'd0;
          cnt_d   = 2'd0;
        end else if (cnt_q == CNT_LAST) begin
          // Only sample while the mux is enabled so a floating Y never lands in data.
          if (!g_n_q) begin
            data_d[sel_q] = bus.y;
          end else begin
            data_d = data_q;
          end
          cnt_d = 2'd0;
          if (sel_q == 3'd7) begin
            // Last channel: disable the mux but leave sel parked on 7 until DONE.
            g_n_d   = 1'b1;
            state_d = S_DONE;
          end else begin
            sel_d = sel_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q + 2'd1;
        end
      end

      S_DONE: begin
        // done is registered here, so it appears one edge after DONE is entered.
        state_d = S_IDLE;
        sel_d   = 3'd0;
        done_d  = 1'b1;
`ifdef MUX_SCAN_PARITY_EN
        parity_d = calc_parity(data_q);
`endif
      end

      default: begin
        state_d = S_IDLE;
        sel_d   = 3'd0;
        g_n_d   = 1'b1;
        cnt_d   = 2'd0;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  // State and output registers with asynchronous reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= 2'd0;
      sel_q   <= 3'd0;
      g_n_q   <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      data_q  <= 8'h00;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sel_q   <= sel_d;
      g_n_q   <= g_n_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      data_q  <= data_d;
    end
  end

`ifdef MUX_SCAN_PARITY_EN
  // Parity register, only updated when a full scan completes
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      parity_q <= 1'b0;
    end else begin
      parity_q <= parity_d;
    end
  end

  assign bus.parity = parity_q;
`endif

  assign bus.sel  = sel_q;
  assign bus.g_n  = g_n_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.data = data_q;

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mux_scan_ctrl
// Directed bench for mux_scan_ctrl. Two instances share clk/rst:
// u0 with SETTLE=1 and u1 with SETTLE=3. Each has a behavioural 8-to-1 mux
// model driving y from a bench-owned D pattern (0 whenever G_n is high).
// Status is compared as {sel, g_n, busy, done}.
// -----------------------------------------------------------------------------
module tb_mux_scan_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mux_scan_ctrl_if if0 ();
  mux_scan_ctrl_if if1 ();

  mux_scan_ctrl #(.SETTLE(1)) u0 (.clk(clk), .rst(rst), .bus(if0.slave));
  mux_scan_ctrl #(.SETTLE(3)) u1 (.clk(clk), .rst(rst), .bus(if1.slave));

  logic [7:0] d0 = 8'h00;
  logic [7:0] d1 = 8'h00;

  // Mux models: output forced low while disabled
  assign if0.y = ~if0.g_n & d0[if0.sel];
  assign if1.y = ~if1.g_n & d1[if1.sel];

  logic [5:0] st0, st1;
  assign st0 = {if0.sel, if0.g_n, if0.busy, if0.done};
  assign st1 = {if1.sel, if1.g_n, if1.busy, if1.done};

  localparam logic [5:0] ST_IDLE = {3'd0, 1'b1, 1'b0, 1'b0};

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic [7:0] d;
    logic [7:0] exp_data;
    logic       exp_par;
    int         poke;      // edge at which start is pulsed while busy (0 = none)
    bit         ab_done;   // pulse abort while in DONE
  } vec_t;

  vec_t tbl [7];

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic set_in(input int inst, input logic s, input logic a);
    if (inst == 0) begin
      if0.start = s;
      if0.abort = a;
    end else begin
      if1.start = s;
      if1.abort = a;
    end
  endtask

  function automatic logic [5:0] rd_st(input int inst);
    return (inst == 0) ? st0 : st1;
  endfunction

  function automatic logic [7:0] rd_data(input int inst);
    return (inst == 0) ? if0.data : if1.data;
  endfunction

`ifdef MUX_SCAN_PARITY_EN
  function automatic logic rd_par(input int inst);
    return (inst == 0) ? if0.parity : if1.parity;
  endfunction
`endif

  // One full scan: start accepted at edge 0, every later edge checked.
  task automatic scan(input int inst, input logic [7:0] d, input logic [7:0] exp_data,
                      input logic exp_par, input int s, input int poke, input bit ab_done);
    logic [5:0] exp;
    if (inst == 0) d0 = d; else d1 = d;
    set_in(inst, 1'b1, 1'b0);
    @(posedge clk); #1;
    set_in(inst, 1'b0, 1'b0);
    chk("accept", 16'(rd_st(inst)), 16'({3'd0, 1'b0, 1'b1, 1'b0}));
    for (int e = 1; e <= 8 * s + 1; e++) begin
      @(posedge clk); #1;
      if (poke != 0 && e == poke) set_in(inst, 1'b1, 1'b0);
      else if (poke != 0 && e == poke + 1) set_in(inst, 1'b0, 1'b0);
      if (ab_done && e == 8 * s) set_in(inst, 1'b0, 1'b1);
      else if (ab_done && e == 8 * s + 1) set_in(inst, 1'b0, 1'b0);
      if (e < 8 * s)       exp = {3'(e / s), 1'b0, 1'b1, 1'b0};
      else if (e == 8 * s) exp = {3'd7, 1'b1, 1'b1, 1'b0};
      else                 exp = {3'd0, 1'b1, 1'b0, 1'b1};
      chk($sformatf("scan%0d edge%0d", inst, e), 16'(rd_st(inst)), 16'(exp));
    end
    chk($sformatf("data%0d", inst), 16'(rd_data(inst)), 16'(exp_data));
`ifdef MUX_SCAN_PARITY_EN
    chk($sformatf("parity%0d", inst), 16'(rd_par(inst)), 16'(exp_par));
`endif
    @(posedge clk); #1;
    chk("done drop", 16'(rd_st(inst)), 16'(ST_IDLE));
  endtask

  initial begin
    logic acc;
    set_in(0, 1'b0, 1'b0);
    set_in(1, 1'b0, 1'b0);

    //            d      data   par poke ab_done
    tbl[0] = '{8'hA5, 8'hA5, 1'b0, 0, 1'b0};
    tbl[1] = '{8'h3C, 8'h3C, 1'b0, 0, 1'b0};
    tbl[2] = '{8'h07, 8'h07, 1'b1, 0, 1'b0};
    tbl[3] = '{8'h00, 8'h00, 1'b0, 0, 1'b1};
    tbl[4] = '{8'h80, 8'h80, 1'b1, 0, 1'b0};
    tbl[5] = '{8'h5B, 8'h5B, 1'b1, 0, 1'b0};
    tbl[6] = '{8'hFF, 8'hFF, 1'b0, 4, 1'b0};

    // Reset state
    #12;
    chk("rst st0", 16'(st0), 16'(ST_IDLE));
    chk("rst st1", 16'(st1), 16'(ST_IDLE));
    chk("rst data0", 16'(if0.data), 16'h0000);
`ifdef MUX_SCAN_PARITY_EN
    chk("rst par0", 16'(if0.parity), 16'h0000);
`endif
    @(negedge clk) rst = 1'b0;

    // Table-driven full scans, SETTLE=1
    foreach (tbl[i]) begin
      scan(0, tbl[i].d, tbl[i].exp_data, tbl[i].exp_par, 1, tbl[i].poke, tbl[i].ab_done);
    end

    // SETTLE=3 scan
    scan(1, 8'h3C, 8'h3C, 1'b0, 3, 0, 1'b0);

    // No extra scan after the start pulsed while busy (tbl[6])
    acc = 1'b0;
    repeat (5) begin
      @(posedge clk); #1;
      acc = acc | if0.busy;
    end
    chk("no requeue", 16'(acc), 16'h0000);

    // Abort at sel=4 from cleared data
    @(negedge clk) rst = 1'b1;
    @(negedge clk) rst = 1'b0;
    chk("data cleared", 16'(if0.data), 16'h0000);
    d0 = 8'hFF;
    set_in(0, 1'b1, 1'b0);
    @(posedge clk); #1;
    set_in(0, 1'b0, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    chk("pre-abort sel4", 16'(st0), 16'({3'd4, 1'b0, 1'b1, 1'b0}));
    set_in(0, 1'b0, 1'b1);
    @(posedge clk); #1;
    set_in(0, 1'b0, 1'b0);
    chk("abort st", 16'(st0), 16'(ST_IDLE));
    chk("abort data", 16'(if0.data), 16'h000F);
    acc = 1'b0;
    repeat (12) begin
      @(posedge clk); #1;
      acc = acc | if0.done | if0.busy;
    end
    chk("abort no done", 16'(acc), 16'h0000);
`ifdef MUX_SCAN_PARITY_EN
    chk("abort par", 16'(if0.parity), 16'h0000);
`endif

    // start+abort together in IDLE: stays idle
    set_in(0, 1'b1, 1'b1);
    acc = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
      acc = acc | if0.busy;
    end
    chk("start+abort idle", 16'(acc), 16'h0000);

    // start held high: new scan on first IDLE edge after done
    set_in(0, 1'b1, 1'b0);
    repeat (10) @(posedge clk);
    #1;
    chk("held start done", 16'(st0), 16'({3'd0, 1'b1, 1'b0, 1'b1}));
    @(posedge clk); #1;
    chk("held start restart", 16'(st0), 16'({3'd0, 1'b0, 1'b1, 1'b0}));
    set_in(0, 1'b0, 1'b1);
    @(posedge clk); #1;
    set_in(0, 1'b0, 1'b0);
    chk("held start abort", 16'(st0), 16'(ST_IDLE));

    // Asynchronous reset between edges mid-scan
    d0 = 8'hFF;
    set_in(0, 1'b1, 1'b0);
    @(posedge clk); #1;
    set_in(0, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk("async rst st", 16'(st0), 16'(ST_IDLE));
    chk("async rst data", 16'(if0.data), 16'h0000);
    @(negedge clk) rst = 1'b0;
    scan(0, 8'h81, 8'h81, 1'b0, 1, 0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mux_scan_ctrl.md
MUX_SCAN_CTRL -- requirements
Module: mux_scan_ctrl

Interface
REQ-001 SHALL have parameter SETTLE, default 1, meaning cycles each select value is held before Y is sampled; legal range 1..4.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on the rising edge.
REQ-003 SHALL have port rst, input, 1, reset, asynchronous and active-high.
REQ-004 SHALL have port start, input, 1, scan request, sampled only in IDLE.
REQ-005 SHALL have port abort, input, 1, terminates an active scan.
REQ-006 SHALL have port y, input, 1, the 8-to-1 mux Y output being scanned.
REQ-007 SHALL have port sel, output, 3, the mux select; bit 2 drives S2, bit 1 drives S1, bit 0 drives S0.
REQ-008 SHALL have port g_n, output, 1, the active-low mux enable, driving G_n.
REQ-009 SHALL have port busy, output, 1, high whenever state is not IDLE.
REQ-010 SHALL have port done, output, 1, a one-cycle pulse when a full scan completes.
REQ-011 SHALL have port data, output, 8, the captured channels; data[i] is D(i) as seen on y.

Function
REQ-012 SHALL implement states IDLE, SCAN and DONE, all registered; no output is combinational from inputs.
REQ-013 IDLE with start=1 and abort=0 at an edge SHALL load sel=0, g_n=0, hold counter=0 and enter SCAN.
REQ-014 In SCAN, each edge with hold counter < SETTLE-1 SHALL increment the counter, with sel held.
REQ-015 In SCAN, an edge with hold counter = SETTLE-1 SHALL write data[sel] <= y and clear the counter.
REQ-016 On that same edge, sel SHALL increment if sel < 7; if sel = 7, the block SHALL set g_n=1, keep sel=7 and enter DONE.
REQ-017 DONE SHALL assert done for exactly one cycle, then return to IDLE with sel=0; data SHALL hold until the next capture.
REQ-018 Latency: done SHALL be high in the cycle beginning 8*SETTLE+1 edges after the start-accepting edge.
REQ-019 start while busy=1 SHALL be ignored (no queuing); start held high SHALL begin a new scan on the first IDLE edge after DONE.
REQ-020 abort=1 in SCAN SHALL move to IDLE at that edge with g_n=1 and sel=0, with no done pulse and no capture on that edge; channels already captured SHALL be retained.
REQ-021 abort=1 together with start=1 in IDLE SHALL keep the block in IDLE (abort wins); abort in DONE SHALL be ignored.
REQ-022 y SHALL be sampled only in SCAN with g_n=0, so a high-impedance y while disabled is never captured.

Reset
REQ-023 rst=1 SHALL immediately force state=IDLE, sel=0, g_n=1, busy=0, done=0, data=8'h00 and hold counter=0, regardless of clk.
REQ-024 rst asserted mid-scan SHALL abort the scan with no done pulse; after rst falls, operation SHALL resume from IDLE on the next clk edge.

Configuration
REQ-025 With macro MUX_SCAN_PARITY_EN defined, the block SHALL add output port parity (1 bit), registered on the DONE transition, equal to XOR of the eight captured bits, reset value 0, and unchanged on abort.
REQ-026 Without MUX_SCAN_PARITY_EN, the parity port and its logic SHALL be absent; all other behaviour SHALL be identical.

Verification
REQ-027 Bench SHALL cover: SETTLE=1, mux D7..D0=8'hA5, one-cycle start -> sel steps 0..7 one per cycle; g_n low for 8 cycles; done high 9 edges after start; data=8'hA5; parity=0 if enabled.
REQ-028 Bench SHALL cover: SETTLE=3, D=8'h3C -> each sel value held 3 cycles; done after 25 edges; data=8'h3C.
REQ-029 Bench SHALL cover: abort asserted while sel=4, D=8'hFF from data=8'h00 -> IDLE at next edge; data=8'h0F; no done; g_n=1.
REQ-030 Bench SHALL cover: start pulsed again while busy, and start+abort together in IDLE -> no extra scan; busy=0 remains in the second case.
REQ-031 Bench SHALL cover: rst asserted asynchronously mid-scan between edges -> outputs reach reset values before the next edge; a following start gives a clean scan of D=8'h81 with data=8'h81 and parity=0.
